lab6_fir_seq: RTL and testbench
===============================

Name: lab6_fir_seq

Overview:
- Parametrised, time-multiplexed FIR filter. One shared signed multiplier; one multiply-accumulate per clock.
- Generalises the fixed 3-constant lab6 datapath:
  - NTAPS taps with run-time loadable coefficients.
  - Signed fixed-point arithmetic with output saturation.
  - Drop detection on the irdy/ordy handshake.
- Sits between the sample source (irdy/din) and the output consumer (ordy/dout).

Parameters:
- DW, 10: sample width, signed two's complement.
- CW, 12: coefficient width, signed Q1.(CW-1); 0x400 = 0.5 at CW=12.
- NTAPS, 3: tap count, 2..16.

Ports:
- clk  in  1  clock; all state on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- irdy  in  1  input sample valid, sampled on the clk edge.
- din  in  DW  input sample, signed.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  4  tap index to write.
- coef_data  in  CW  coefficient value, signed.
- dout  out  DW  filtered output, signed; held until the next result.
- ordy  out  1  level: dout valid.
- busy  out  1  high while a computation is in flight.
- ovf  out  1  sticky: an input sample was dropped.

Behaviour:
- Reset (asynchronous):
  - Outputs: dout=0, ordy=0, busy=0, ovf=0.
  - Internal: delay line x[0..NTAPS-1]=0, all coefficients c[i]=0, acc=0, state=IDLE.
  - Reset asserted mid-computation aborts it; no result is produced.
- States: IDLE, MAC, OUT. busy = (state != IDLE).
- IDLE with irdy=1 (sample accepted):
  - Shift the delay line: x[0]<=din, x[i]<=x[i-1].
  - acc<=0, idx<=0, ordy<=0, state<=MAC.
  - Applies even when ordy=1 in the same cycle: ordy clears on that edge.
- MAC:
  - Each edge: acc <= acc + x[idx]*c[idx]; idx++.
  - After the edge with idx=NTAPS-1, state<=OUT.
  - Exactly NTAPS MAC edges.
- OUT (one edge): dout <= sat(shift(acc)), ordy<=1, state<=IDLE.
- Latency: ordy rises NTAPS+1 clock edges after the accepting edge (4 edges at NTAPS=3). Minimum sample spacing is NTAPS+2 cycles.
- Widths:
  - Product: DW+CW bits.
  - acc: DW+CW+clog2(NTAPS) bits, cannot overflow.
  - shift(acc): arithmetic shift right by CW-1.
  - sat(): clamp to [-2^(DW-1), 2^(DW-1)-1] ([-512, 511] at DW=10).
- irdy while busy: the sample is dropped; delay line and acc unaffected; ovf<=1. ovf clears only on reset.
- Coefficient writes:
  - coef_we in IDLE with coef_addr<NTAPS: c[coef_addr]<=coef_data at that edge.
  - coef_we while busy: ignored; ovf unaffected.
  - coef_addr>=NTAPS: ignored.
  - coef_we and irdy on the same IDLE edge: the write lands at that edge, but the computation started on that edge already uses the new coefficient, because MAC reads c[] from the next edge onward.
- dout and ordy never change in IDLE except through accept (ordy<=0) or reset.

Optional Feature:
- Macro: LAB6_FIR_ROUND_EN.
- Defined: round half-up before saturation. Add 2^(CW-2) to acc, then shift.
- Undefined: truncate; the arithmetic shift floors toward minus infinity.
- Latency and every other behaviour are identical in both builds.

Test Plan:
- Impulse:
  - Stimulus: c={0x400,0x200,0x200}; din sequence 100, 0, 0, each sent after ordy.
  - Response: dout=50, 25, 25; ordy rises 4 edges after each accept.
- Saturation:
  - Positive: c={0x7FF,0x7FF,0x7FF}; din=511 three times. Third dout=511 (clamped); no wrap.
  - Negative: c={0x800,0,0}; din=-512. dout=511.
- Rounding:
  - Stimulus: c={0x400,0,0}; din=3, then din=-3.
  - Without LAB6_FIR_ROUND_EN: dout=1, then -2.
  - With LAB6_FIR_ROUND_EN: dout=2, then -1.
- Drop:
  - Stimulus: irdy pulsed 2 cycles after an accepted sample of 100 (c={0x400,0x200,0x200}).
  - Response: ovf=1; that result is still dout=50; the dropped sample never enters the delay line.
- Reset mid-MAC:
  - Stimulus: assert reset between the two clk edges following an accept.
  - Response: immediately busy=0, ordy=0, dout=0, ovf=0.
  - After release: coefficients read 0; din=200 produces dout=0.
- Coefficient write while busy: write c[0]=0x7FF during MAC → ignored; next result still uses 0x400.

Source files
------------

// File: rtl/lab6_fir_seq.sv
// Time-multiplexed FIR: one shared signed multiplier, one MAC per clock, NTAPS taps.
// Optional build macro LAB6_FIR_ROUND_EN selects round-half-up instead of truncation.
module lab6_fir_seq #(
    parameter int DW    = 10,
    parameter int CW    = 12,
    parameter int NTAPS = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 irdy,
    input  logic signed [DW-1:0] din,
    input  logic                 coef_we,
    input  logic [3:0]           coef_addr,
    input  logic signed [CW-1:0] coef_data,
    output logic signed [DW-1:0] dout,
    output logic                 ordy,
    output logic                 busy,
    output logic                 ovf
);

    localparam int IW = $clog2(NTAPS);
    localparam int PW = DW + CW;
    localparam int AW = PW + IW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    localparam logic [IW-1:0] LAST_IDX = IW'(NTAPS - 1);
    localparam logic [4:0]    NTAPS_L  = 5'(NTAPS);

    localparam logic signed [AW-1:0] SAT_MAX = $signed({{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}});
    localparam logic signed [AW-1:0] SAT_MIN = $signed({{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}});
    localparam logic signed [AW-1:0] RND     = $signed({{(AW-CW+1){1'b0}}, 1'b1, {(CW-2){1'b0}}});

    logic [1:0]           r_state;
    logic [IW-1:0]        r_idx;
    logic signed [DW-1:0] r_x [NTAPS];
    logic signed [CW-1:0] r_c [NTAPS];
    logic signed [AW-1:0] r_acc;
    logic signed [DW-1:0] r_dout;
    logic                 r_ordy;
    logic                 r_ovf;

    logic signed [DW-1:0] w_xs;
    logic signed [CW-1:0] w_cs;
    logic signed [PW-1:0] w_prod;
    logic signed [AW-1:0] w_prod_ext;
    logic                 w_addr_ok;

    // Scale the Q1.(CW-1) accumulator back to sample units and clamp to DW bits.
    function automatic logic signed [DW-1:0] sat_shift(input logic signed [AW-1:0] acc);
        logic signed [AW-1:0] v;
`ifdef LAB6_FIR_ROUND_EN
        v = (acc + RND) >>> (CW - 1);
`else
        v = acc >>> (CW - 1);
`endif
        if (v > SAT_MAX)
            sat_shift = SAT_MAX[DW-1:0];
        else if (v < SAT_MIN)
            sat_shift = SAT_MIN[DW-1:0];
        else
            sat_shift = v[DW-1:0];
    endfunction

    assign w_xs       = r_x[r_idx];
    assign w_cs       = r_c[r_idx];
    assign w_prod     = $signed({{CW{w_xs[DW-1]}}, w_xs}) * $signed({{DW{w_cs[CW-1]}}, w_cs});
    assign w_prod_ext = $signed({{IW{w_prod[PW-1]}}, w_prod});
    assign w_addr_ok  = ({1'b0, coef_addr} < NTAPS_L);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_acc   <= '0;
            r_dout  <= '0;
            r_ordy  <= 1'b0;
            r_ovf   <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                r_x[i] <= '0;
                r_c[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A same-edge coefficient write is visible to this sample: MAC starts reading next edge.
                    if (coef_we && w_addr_ok)
                        r_c[coef_addr[IW-1:0]] <= coef_data;
                    if (irdy) begin
                        r_x[0] <= din;
                        for (int i = 1; i < NTAPS; i++)
                            r_x[i] <= r_x[i-1];
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_ordy  <= 1'b0;
                        r_state <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    if (r_idx == LAST_IDX) begin
                        r_idx   <= '0;
                        r_state <= S_OUT;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                    if (irdy)
                        r_ovf <= 1'b1;
                end
                S_OUT: begin
                    r_dout  <= sat_shift(r_acc);
                    r_ordy  <= 1'b1;
                    r_state <= S_IDLE;
                    if (irdy)
                        r_ovf <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dout = r_dout;
    assign ordy = r_ordy;
    assign ovf  = r_ovf;
    assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_lab6_fir_seq.sv
// Scoreboard bench for lab6_fir_seq: a reference model pushes expected outputs on accept.
module tb_lab6_fir_seq;

    localparam int DW    = 10;
    localparam int CW    = 12;
    localparam int NTAPS = 3;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 irdy = 1'b0;
    logic signed [DW-1:0] din = '0;
    logic                 coef_we = 1'b0;
    logic [3:0]           coef_addr = '0;
    logic signed [CW-1:0] coef_data = '0;
    logic signed [DW-1:0] dout;
    logic                 ordy;
    logic                 busy;
    logic                 ovf;

    int n_checks = 0;
    int n_pass   = 0;
    int m_x [NTAPS];
    int m_c [NTAPS];
    int sb [$];

    lab6_fir_seq #(.DW(DW), .CW(CW), .NTAPS(NTAPS)) dut (
        .clk       (clk),
        .reset     (reset),
        .irdy      (irdy),
        .din       (din),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .dout      (dout),
        .ordy      (ordy),
        .busy      (busy),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    function automatic int model_out();
        longint acc;
        longint hi;
        acc = 0;
        hi  = (64'sd1 <<< (DW - 1)) - 1;
        for (int i = 0; i < NTAPS; i++)
            acc += longint'(m_x[i]) * longint'(m_c[i]);
`ifdef LAB6_FIR_ROUND_EN
        acc += (64'sd1 <<< (CW - 2));
`endif
        acc = acc >>> (CW - 1);
        if (acc > hi) acc = hi;
        if (acc < -hi - 1) acc = -hi - 1;
        return int'(acc);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NTAPS; i++) begin
            m_x[i] = 0;
            m_c[i] = 0;
        end
        sb.delete();
    endtask

    task automatic write_coef(input int addr, input int data);
        logic [3:0] a;
        a = addr[3:0];
        @(negedge clk);
        coef_we = 1'b1; coef_addr = a; coef_data = data[CW-1:0];
        if (addr < NTAPS) m_c[addr] = data;
        @(posedge clk); #1;
        coef_we = 1'b0;
    endtask

    // cw_k: -1 none, 0 same edge as accept, >0 that many edges after accept (busy, ignored).
    task automatic run_sample(input int val, input int drop_k, input int cw_k,
                              input int cw_addr, input int cw_data, input string name);
        int got, lat, ev;
        logic [DW-1:0] evb;
        @(negedge clk);
        irdy = 1'b1; din = val[DW-1:0];
        if (cw_k == 0) begin
            coef_we = 1'b1; coef_addr = cw_addr[3:0]; coef_data = cw_data[CW-1:0];
            if (cw_addr < NTAPS) m_c[cw_addr] = cw_data;
        end
        for (int i = NTAPS - 1; i > 0; i--) m_x[i] = m_x[i-1];
        m_x[0] = val;
        sb.push_back(model_out());
        @(posedge clk); #1;
        irdy = 1'b0; coef_we = 1'b0;
        n_checks++;
        if (ordy !== 1'b0 || busy !== 1'b1)
            $display("FAIL %s_accept: ordy=%b busy=%b, required ordy=0 busy=1", name, ordy, busy);
        else n_pass++;
        got = 0; lat = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == drop_k) begin irdy = 1'b1; din = 10'sd300; end
            if (k == cw_k) begin
                coef_we = 1'b1; coef_addr = cw_addr[3:0]; coef_data = cw_data[CW-1:0];
            end
            @(posedge clk); #1;
            irdy = 1'b0; coef_we = 1'b0;
            if (ordy === 1'b1) begin got = 1; lat = k; break; end
        end
        n_checks++;
        if (got == 0 || lat != NTAPS + 1)
            $display("FAIL %s_latency: got=%0d edges=%0d, required %0d edges", name, got, lat, NTAPS + 1);
        else n_pass++;
        ev = (sb.size() > 0) ? sb.pop_front() : 32'h7fffffff;
        evb = ev[DW-1:0];
        n_checks++;
        if (dout !== evb)
            $display("FAIL %s_dout: dout=%0d, required %0d", name, dout, ev);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0)
            $display("FAIL %s_idle: busy=%b, required 0", name, busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (dout !== '0 || ordy !== 1'b0 || busy !== 1'b0 || ovf !== 1'b0)
            $display("FAIL reset_state: dout=%0d ordy=%b busy=%b ovf=%b, required all 0", dout, ordy, busy, ovf);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_impulse();
        logic [DW-1:0] held;
        write_coef(0, 'h400);
        write_coef(1, 'h200);
        write_coef(2, 'h200);
        run_sample(100, 0, -1, 0, 0, "imp0");
        run_sample(0,   0, -1, 0, 0, "imp1");
        run_sample(0,   0, -1, 0, 0, "imp2");
        held = dout;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (dout !== held || ordy !== 1'b1)
            $display("FAIL hold: dout=%0d ordy=%b, required dout=%0d ordy=1", dout, ordy, $signed(held));
        else n_pass++;
    endtask

    task automatic test_saturation();
        write_coef(0, 'h7FF);
        write_coef(1, 'h7FF);
        write_coef(2, 'h7FF);
        run_sample(511, 0, -1, 0, 0, "satp0");
        run_sample(511, 0, -1, 0, 0, "satp1");
        run_sample(511, 0, -1, 0, 0, "satp2");
        write_coef(0, -2048);
        write_coef(1, 0);
        write_coef(2, 0);
        run_sample(-512, 0, -1, 0, 0, "satn");
        run_sample(-300, 0, -1, 0, 0, "satn_mid");
    endtask

    task automatic test_rounding();
        write_coef(0, 'h400);
        run_sample(3,  0, -1, 0, 0, "rnd_pos");
        run_sample(-3, 0, -1, 0, 0, "rnd_neg");
    endtask

    task automatic test_coef_busy();
        write_coef(0, 'h400);
        write_coef(1, 'h200);
        write_coef(2, 'h200);
        run_sample(0,   0, -1, 0, 0,    "clr0");
        run_sample(0,   0, -1, 0, 0,    "clr1");
        run_sample(100, 0, 2,  0, 2047, "cbusy");
        n_checks++;
        if (ovf !== 1'b0)
            $display("FAIL cbusy_ovf: ovf=%b, required 0", ovf);
        else n_pass++;
        run_sample(0, 0, 0, 1, -1024, "csame");
        write_coef(3, 2047);
        write_coef(4, 2047);
        run_sample(40, 0, -1, 0, 0, "caddr");
    endtask

    task automatic test_drop();
        write_coef(0, 'h400);
        write_coef(1, 'h200);
        write_coef(2, 'h200);
        run_sample(0,   0, -1, 0, 0, "dclr0");
        run_sample(0,   0, -1, 0, 0, "dclr1");
        run_sample(100, 2, -1, 0, 0, "drop");
        n_checks++;
        if (ovf !== 1'b1)
            $display("FAIL drop_ovf: ovf=%b, required 1", ovf);
        else n_pass++;
        run_sample(0, 0, -1, 0, 0, "drop_n1");
        run_sample(0, 0, -1, 0, 0, "drop_n2");
        n_checks++;
        if (ovf !== 1'b1)
            $display("FAIL drop_sticky: ovf=%b, required 1", ovf);
        else n_pass++;
    endtask

    task automatic test_reset_mid_mac();
        run_sample(100, 0, -1, 0, 0, "pre_rst");
        @(negedge clk);
        irdy = 1'b1; din = 10'sd100;
        @(posedge clk); #1;
        irdy = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || ordy !== 1'b0 || dout !== '0 || ovf !== 1'b0)
            $display("FAIL rst_mid: busy=%b ordy=%b dout=%0d ovf=%b, required all 0", busy, ordy, dout, ovf);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        run_sample(200, 0, -1, 0, 0, "post_rst");
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_saturation();
        test_rounding();
        test_coef_busy();
        test_drop();
        test_reset_mid_mac();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
